tex_line_fetcher: RTL and testbench

//  Read-side engine for the texture region of dmem. The ARM core writes texture words.

---
 rtl/tex_line_fetcher_if.sv | 26 ++
 rtl/tex_line_fetcher.sv | 147 ++++++++++++++
 tb/tb_tex_line_fetcher.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/tex_line_fetcher_if.sv
// Texture fetcher bus bundle: dmem read port plus the pixel request/response port.
// master = fetcher side, slave = dmem/vga side.
`timescale 1ns/1ps
interface tex_line_fetcher_if;
   logic        mem_re;
   logic [11:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        pix_rd;
   logic [6:0]  pix_x;
   logic [7:0]  pix_out;
   logic        pix_valid;

   modport master (
      output mem_re, mem_addr,
      input  mem_rdata,
      input  pix_rd, pix_x,
      output pix_out, pix_valid
   );

   modport slave (
      input  mem_re, mem_addr,
      output mem_rdata,
      output pix_rd, pix_x,
      input  pix_out, pix_valid
   );
endinterface

// File: rtl/tex_line_fetcher.sv
// Prefetches one texture line per display line from dmem into a ping-pong buffer
// and serves 8-bit pixels from the display half to the vga block.
//
// state | meaning
// IDLE  | no fetch in flight
// FETCH | one dmem read per cycle, WPL reads in total
// DRAIN | last read word is captured; fill buffer becomes valid
`timescale 1ns/1ps
module tex_line_fetcher #(
   parameter int ADDR_BASE = 0,
   parameter int IMG_W     = 112,
   parameter int IMG_H     = 80
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  line_start,
   input  logic [6:0]            line_y,
   tex_line_fetcher_if.master    bus,
   output logic                  fetch_busy,
   output logic                  underrun
);
   localparam int WPL   = IMG_W / 4;
   localparam int IDX_W = $clog2(WPL);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t             state;
   logic               mem_re_q;
   logic [11:0]        mem_addr_q;
   logic [IDX_W-1:0]   rd_idx;
   logic [IDX_W-1:0]   words_left;
   logic               cap_en;
   logic [IDX_W-1:0]   cap_idx;
   logic               disp_sel;
   logic               fill_sel;
   logic [1:0]         blank;
   logic               line_ok;
   logic [11:0]        line_addr;

   logic [31:0]        line_buf [2][WPL];

   logic               pix_in_range;
   logic [IDX_W-1:0]   pix_word_idx;
   logic [31:0]        pix_word;
   logic [7:0]         pix_byte;
   logic [7:0]         pix_out_q;
   logic               pix_valid_q;

   assign fill_sel     = ~disp_sel;
   assign line_ok      = 32'(line_y) < IMG_H;
   // 12-bit wrap here means ADDR_BASE/IMG_H do not fit the dmem window
   assign line_addr    = 12'(ADDR_BASE) + 12'(line_y) * 12'(WPL);

   assign bus.mem_re    = mem_re_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.pix_out   = pix_out_q;
   assign bus.pix_valid = pix_valid_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         mem_re_q   <= 1'b0;
         mem_addr_q <= '0;
         rd_idx     <= '0;
         words_left <= '0;
         cap_en     <= 1'b0;
         cap_idx    <= '0;
         fetch_busy <= 1'b0;
         underrun   <= 1'b0;
         disp_sel   <= 1'b0;
         blank      <= 2'b11;
      end else begin
         cap_en  <= mem_re_q;
         cap_idx <= rd_idx;
         if (line_start) begin
            // Old fill buffer becomes the display buffer; the old display buffer is refilled.
            disp_sel        <= ~disp_sel;
            blank[disp_sel] <= 1'b1;
            cap_en          <= 1'b0;
            if (fetch_busy) begin
               underrun        <= 1'b1;
               blank[fill_sel] <= 1'b1;
            end
            if (line_ok) begin
               state      <= FETCH;
               mem_re_q   <= 1'b1;
               mem_addr_q <= line_addr;
               rd_idx     <= '0;
               words_left <= IDX_W'(WPL - 1);
               fetch_busy <= 1'b1;
            end else begin
               state      <= IDLE;
               mem_re_q   <= 1'b0;
               fetch_busy <= 1'b0;
            end
         end else begin
            case (state)
               FETCH: begin
                  if (words_left == '0) begin
                     state    <= DRAIN;
                     mem_re_q <= 1'b0;
                  end else begin
                     words_left <= words_left - 1'b1;
                     rd_idx     <= rd_idx + 1'b1;
                     mem_addr_q <= mem_addr_q + 12'd1;
                  end
               end
               DRAIN: begin
                  state           <= IDLE;
                  fetch_busy      <= 1'b0;
                  blank[fill_sel] <= 1'b0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Buffer RAM is deliberately not reset; blank flags gate its contents.
   always_ff @(posedge clk) begin
      if (cap_en)
         line_buf[fill_sel][cap_idx] <= bus.mem_rdata;
   end

   always_comb begin
      pix_in_range = 32'(bus.pix_x) < IMG_W;
      pix_word_idx = pix_in_range ? IDX_W'(bus.pix_x >> 2) : '0;
      pix_word     = line_buf[disp_sel][pix_word_idx];
      case (bus.pix_x[1:0])
         2'd0:    pix_byte = pix_word[7:0];
         2'd1:    pix_byte = pix_word[15:8];
         2'd2:    pix_byte = pix_word[23:16];
         default: pix_byte = pix_word[31:24];
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pix_valid_q <= 1'b0;
         pix_out_q   <= 8'h00;
      end else begin
         pix_valid_q <= bus.pix_rd;
         if (bus.pix_rd)
            pix_out_q <= (pix_in_range && !blank[disp_sel]) ? pix_byte : 8'h00;
      end
   end
endmodule

// File: tb/tb_tex_line_fetcher.sv
// Directed bench for tex_line_fetcher: behavioural dmem, line fetch timing,
// ping-pong display lag, out-of-range lines, underrun abort and mid-fetch reset.
`timescale 1ns/1ps
module tb_tex_line_fetcher;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       line_start = 1'b0;
   logic [6:0] line_y = '0;
   logic       fetch_busy;
   logic       underrun;

   logic [31:0] dmem [4096];
   logic [11:0] addr_log [1024];
   int          total_re = 0;
   int          checks = 0;
   int          failures = 0;
   int          base;

   tex_line_fetcher_if bus();

   tex_line_fetcher dut (
      .clk        (clk),
      .reset      (reset),
      .line_start (line_start),
      .line_y     (line_y),
      .bus        (bus),
      .fetch_busy (fetch_busy),
      .underrun   (underrun)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      if (bus.mem_re)
         bus.mem_rdata <= dmem[bus.mem_addr];
   end

   always @(negedge clk) begin
      if (bus.mem_re === 1'b1) begin
         if (total_re < 1024)
            addr_log[total_re] = bus.mem_addr;
         total_re = total_re + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic pulse(input logic [6:0] y);
      line_start = 1'b1;
      line_y     = y;
      tick();
      line_start = 1'b0;
   endtask

   task automatic pix(input logic [6:0] x, input logic [7:0] exp, input string tag);
      bus.pix_rd = 1'b1;
      bus.pix_x  = x;
      tick();
      bus.pix_rd = 1'b0;
      chk({tag, "_valid"}, 32'(bus.pix_valid), 32'd1);
      chk(tag, 32'(bus.pix_out), 32'(exp));
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (fetch_busy !== 1'b0 && n < 100) begin
         tick();
         n++;
      end
      chk(tag, 32'(fetch_busy), 32'd0);
   endtask

   initial begin
      // Line 1 (words 28..55) carries pixel value == column; elsewhere a per-address pattern.
      for (int a = 0; a < 4096; a++) begin
         logic [7:0] b;
         b = 8'(a);
         if (a >= 28 && a <= 55)
            dmem[a] = 32'h03020100 + 32'(a - 28) * 32'h04040404;
         else
            dmem[a] = {b, ~b, 8'h5A, b + 8'h11};
      end
      bus.pix_rd = 1'b0;
      bus.pix_x  = '0;

      repeat (3) tick();
      chk("rst_mem_re",    32'(bus.mem_re),    32'd0);
      chk("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
      chk("rst_pix_valid", 32'(bus.pix_valid), 32'd0);
      chk("rst_pix_out",   32'(bus.pix_out),   32'd0);
      chk("rst_busy",      32'(fetch_busy),    32'd0);
      chk("rst_underrun",  32'(underrun),      32'd0);
      reset = 1'b1;
      tick();

      // Test 1: line 1 fetch timing and addresses
      pulse(7'd1);
      for (int n = 1; n <= 30; n++) begin
         chk("t1_re", 32'(bus.mem_re), 32'(n <= 28));
         if (n <= 28)
            chk("t1_addr", 32'(bus.mem_addr), 32'(27 + n));
         chk("t1_busy", 32'(fetch_busy), 32'(n <= 29));
         tick();
      end

      // Test 2 / 6: display shows line 1 after the next swap
      pulse(7'd2);
      pix(7'd0,   8'h00, "t2_x0");
      pix(7'd5,   8'h05, "t2_x5");
      pix(7'd111, 8'h6F, "t2_x111");
      tick();
      chk("t2_hold_valid", 32'(bus.pix_valid), 32'd0);
      chk("t2_hold_out",   32'(bus.pix_out),   32'h6F);
      pix(7'd112, 8'h00, "t6_x112");
      pix(7'd127, 8'h00, "t6_x127");
      wait_idle("t2_idle");

      // Test 3: out-of-range line, then pre-swap read and blank display
      base = total_re;
      pulse(7'd80);
      chk("t3_busy", 32'(fetch_busy), 32'd0);
      repeat (30) tick();
      chk("t3_no_re", 32'(total_re - base), 32'd0);
      pix(7'd4, 8'h4A, "t3_line2_x4");
      pix(7'd7, 8'h39, "t3_line2_x7");
      line_start = 1'b1;
      line_y     = 7'd5;
      bus.pix_rd = 1'b1;
      bus.pix_x  = 7'd4;
      tick();
      line_start = 1'b0;
      bus.pix_rd = 1'b0;
      chk("t3_preswap", 32'(bus.pix_out), 32'h4A);
      pix(7'd0,   8'h00, "t3_blank_x0");
      pix(7'd50,  8'h00, "t3_blank_x50");
      pix(7'd111, 8'h00, "t3_blank_x111");
      wait_idle("t3_idle");
      chk("t3_no_underrun", 32'(underrun), 32'd0);

      // Test 4: line_start 10 cycles into a fetch
      base = total_re;
      pulse(7'd3);
      repeat (9) tick();
      line_start = 1'b1;
      line_y     = 7'd4;
      tick();
      line_start = 1'b0;
      chk("t4_underrun",    32'(underrun),         32'd1);
      chk("t4_line3_reads", 32'(total_re - base),  32'd10);
      chk("t4_addr0",       32'(bus.mem_addr),     32'd112);
      chk("t4_busy",        32'(fetch_busy),       32'd1);
      base = total_re;
      pix(7'd0,  8'h00, "t4_line3_x0");
      pix(7'd40, 8'h00, "t4_line3_x40");
      wait_idle("t4_idle");
      chk("t4_line4_reads", 32'(total_re - base), 32'd28);
      chk("t4_first_addr",  32'(addr_log[base]),   32'd112);
      chk("t4_last_addr",   32'(addr_log[base + 27]), 32'd139);
      pulse(7'd6);
      pix(7'd0,   8'h81, "t4_line4_x0");
      pix(7'd1,   8'h5A, "t4_line4_x1");
      pix(7'd2,   8'h8F, "t4_line4_x2");
      pix(7'd3,   8'h70, "t4_line4_x3");
      pix(7'd111, 8'h8B, "t4_line4_x111");
      chk("t4_sticky", 32'(underrun), 32'd1);
      wait_idle("t4_idle2");

      // Test 5: reset asserted on the 12th read
      pulse(7'd7);
      repeat (11) tick();
      chk("t5_re12",   32'(bus.mem_re),   32'd1);
      chk("t5_addr12", 32'(bus.mem_addr), 32'd207);
      reset = 1'b0;
      #1;
      chk("t5_rst_re",        32'(bus.mem_re),    32'd0);
      chk("t5_rst_addr",      32'(bus.mem_addr),  32'd0);
      chk("t5_rst_busy",      32'(fetch_busy),    32'd0);
      chk("t5_rst_underrun",  32'(underrun),      32'd0);
      chk("t5_rst_pix_valid", 32'(bus.pix_valid), 32'd0);
      chk("t5_rst_pix_out",   32'(bus.pix_out),   32'd0);
      base = total_re;
      repeat (2) tick();
      chk("t5_rst_no_re", 32'(total_re - base), 32'd0);
      reset = 1'b1;
      tick();
      pix(7'd5, 8'h00, "t5_after_rst");
      pulse(7'd1);
      wait_idle("t5_idle1");
      pix(7'd5, 8'h00, "t5_one_ls");
      pulse(7'd2);
      pix(7'd5,   8'h05, "t5_two_ls_x5");
      pix(7'd111, 8'h6F, "t5_two_ls_x111");
      wait_idle("t5_idle2");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
